// File: rtl/instr_byte_queue_pkg.sv
// Shared constants and helpers for the instruction byte queue and its shifter.
package instr_byte_queue_pkg;

    localparam int MAX_INSTR_BYTES = 15;
    localparam int FETCH_BYTES     = 4;
    localparam int WINDOW_BYTES    = MAX_INSTR_BYTES;
    localparam int DEPTH_BYTES     = 24;
    localparam int CNT_W           = 5;
    localparam int LEN_W           = 4;

    // Saturate a byte count to the size of the decode window.
    function automatic logic [CNT_W-1:0] sat_window(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_W'(WINDOW_BYTES)) begin
            return CNT_W'(WINDOW_BYTES);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/instr_byte_queue_byte_shifter.sv
// Zero-filling byte barrel shifter with an optional fetch-word merge at the
// new tail. Generic enough to serve the prefix stripper's shift as well.
module byte_shifter
    import instr_byte_queue_pkg::*;
#(
    parameter int NBYTES = DEPTH_BYTES
) (
    input  logic [8*NBYTES-1:0]     i_buf,
    input  logic [CNT_W-1:0]        i_count,
    input  logic [LEN_W-1:0]        i_shift,
    input  logic                    i_merge_en,
    input  logic [8*FETCH_BYTES-1:0] i_data,
    output logic [8*NBYTES-1:0]     o_buf
);

    logic [8*NBYTES-1:0] w_shifted;
    logic [CNT_W-1:0]    w_base;

    // Drop the consumed head bytes, then drop the fetch word just past the survivors.
    always_comb begin
        w_shifted = i_buf >> {i_shift, 3'b000};
        w_base    = i_count - {1'b0, i_shift};
        o_buf     = w_shifted;
        if (i_merge_en) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                o_buf[{w_base + CNT_W'(k), 3'b000} +: 8] = i_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/instr_byte_queue.sv
// Byte-granular instruction queue feeding the decode front end: accepts 4-byte
// fetch words, exposes the oldest 15 bytes and retires variable-length instructions.
module instr_byte_queue
    import instr_byte_queue_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic [31:0]               i_flush_eip,
    input  logic [8*FETCH_BYTES-1:0]  i_fetch_data,
    input  logic                      i_fetch_valid,
    output logic                      o_fetch_ready,
    output logic [8*WINDOW_BYTES-1:0] o_window,
    output logic [CNT_W-1:0]          o_window_bytes,
    output logic                      o_window_full,
    output logic [31:0]               o_head_eip,
    input  logic                      i_consume_valid,
    input  logic [LEN_W-1:0]          i_consume_len,
    output logic                      o_underrun_err
);

    logic [8*DEPTH_BYTES-1:0] r_buf;
    logic [CNT_W-1:0]         r_count;
    logic [31:0]              r_head_eip;
    logic                     r_underrun_err;

    logic                     w_fetch_fire;
    logic                     w_len_ok;
    logic                     w_consume_legal;
    logic                     w_consume_illegal;
    logic [LEN_W-1:0]         w_shift;
    logic [CNT_W-1:0]         w_fetch_add;
    logic [8*DEPTH_BYTES-1:0] w_next_buf;

    // Handshake and consume legality; ready depends only on the registered count.
    always_comb begin
        o_fetch_ready     = (r_count <= CNT_W'(DEPTH_BYTES - FETCH_BYTES));
        w_fetch_fire      = i_fetch_valid && o_fetch_ready;
        w_len_ok          = (i_consume_len != '0) && ({1'b0, i_consume_len} <= r_count);
        w_consume_legal   = i_consume_valid && w_len_ok;
        w_consume_illegal = i_consume_valid && !w_len_ok;
        w_shift           = w_consume_legal ? i_consume_len : '0;
        w_fetch_add       = w_fetch_fire ? CNT_W'(FETCH_BYTES) : '0;
    end

    byte_shifter #(
        .NBYTES (DEPTH_BYTES)
    ) u_shifter (
        .i_buf      (r_buf),
        .i_count    (r_count),
        .i_shift    (w_shift),
        .i_merge_en (w_fetch_fire),
        .i_data     (i_fetch_data),
        .o_buf      (w_next_buf)
    );

    // Buffer, count and head address; flush overrides any same-cycle fetch or consume.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf      <= '0;
            r_count    <= '0;
            r_head_eip <= '0;
        end else if (i_flush) begin
            r_buf      <= '0;
            r_count    <= '0;
            r_head_eip <= i_flush_eip;
        end else begin
            r_buf      <= w_next_buf;
            r_count    <= r_count - {1'b0, w_shift} + w_fetch_add;
            r_head_eip <= r_head_eip + {28'd0, w_shift};
        end
    end

    // Sticky underrun flag; only reset clears it, a flushed-away consume never sets it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_underrun_err <= 1'b0;
        end else if (!i_flush && w_consume_illegal) begin
            r_underrun_err <= 1'b1;
        end
    end

    // Window view of the buffer head, purely from registered state.
    always_comb begin
        o_window       = r_buf[8*WINDOW_BYTES-1:0];
        o_window_bytes = sat_window(r_count);
        o_window_full  = (r_count >= CNT_W'(WINDOW_BYTES));
        o_head_eip     = r_head_eip;
        o_underrun_err = r_underrun_err;
    end

    // The byte count can never grow beyond the buffer capacity.
    assert property (@(posedge i_clk) disable iff (i_rst) r_count <= CNT_W'(DEPTH_BYTES));

endmodule

// File: tb/tb_instr_byte_queue.sv
// Directed bench for instr_byte_queue with a byte-queue scoreboard model.
module tb_instr_byte_queue;
    import instr_byte_queue_pkg::*;

    logic         clock;
    logic         reset;
    logic         flush;
    logic [31:0]  flushEip;
    logic [31:0]  fetchData;
    logic         fetchValid;
    logic         fetchReady;
    logic [119:0] window;
    logic [4:0]   windowBytes;
    logic         windowFull;
    logic [31:0]  headEip;
    logic         consumeValid;
    logic [3:0]   consumeLen;
    logic         underrunErr;

    int nCompared;
    int nMismatched;

    // Scoreboard: bytes pushed when a fetch is accepted, popped when consumed.
    logic [7:0]  modelQ[$];
    logic [31:0] modelEip;
    logic        modelErr;

    instr_byte_queue dut (
        .i_clk           (clock),
        .i_rst           (reset),
        .i_flush         (flush),
        .i_flush_eip     (flushEip),
        .i_fetch_data    (fetchData),
        .i_fetch_valid   (fetchValid),
        .o_fetch_ready   (fetchReady),
        .o_window        (window),
        .o_window_bytes  (windowBytes),
        .o_window_full   (windowFull),
        .o_head_eip      (headEip),
        .i_consume_valid (consumeValid),
        .i_consume_len   (consumeLen),
        .o_underrun_err  (underrunErr)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the scoreboard state.
    task automatic checkModel(input string tag);
        logic [119:0] expWin;
        int           n;
        expWin = '0;
        n = modelQ.size();
        for (int i = 0; i < n && i < WINDOW_BYTES; i++) begin
            expWin[8*i +: 8] = modelQ[i];
        end
        checkOutput({tag, ".window"}, {8'd0, window}, {8'd0, expWin});
        checkOutput({tag, ".bytes"}, {123'd0, windowBytes}, 128'((n > 15) ? 15 : n));
        checkOutput({tag, ".full"}, {127'd0, windowFull}, {127'd0, n >= 15});
        checkOutput({tag, ".ready"}, {127'd0, fetchReady}, {127'd0, n <= 20});
        checkOutput({tag, ".eip"}, {96'd0, headEip}, {96'd0, modelEip});
        checkOutput({tag, ".err"}, {127'd0, underrunErr}, {127'd0, modelErr});
    endtask

    // Drive one cycle of stimulus, predict its effect, and release the inputs after the edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic cv,
                                 input logic [3:0] cl, input logic fl, input logic [31:0] fe);
        logic fire;
        logic legal;
        int   n;
        fetchValid   = fv;
        fetchData    = fd;
        consumeValid = cv;
        consumeLen   = cl;
        flush        = fl;
        flushEip     = fe;
        n     = modelQ.size();
        fire  = fv && (n <= 20);
        legal = cv && (cl >= 1) && (int'(cl) <= n);
        @(posedge clock);
        #1;
        if (fl) begin
            modelQ.delete();
            modelEip = fe;
        end else begin
            if (legal) begin
                for (int i = 0; i < int'(cl); i++) void'(modelQ.pop_front());
                modelEip = modelEip + 32'(cl);
            end else if (cv) begin
                modelErr = 1'b1;
            end
            if (fire) begin
                for (int k = 0; k < 4; k++) modelQ.push_back(fd[8*k +: 8]);
            end
        end
        fetchValid   = 1'b0;
        consumeValid = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        nCompared    = 0;
        nMismatched  = 0;
        modelEip     = '0;
        modelErr     = 1'b0;
        reset        = 1'b1;
        flush        = 1'b0;
        flushEip     = '0;
        fetchData    = '0;
        fetchValid   = 1'b0;
        consumeValid = 1'b0;
        consumeLen   = '0;

        #12;
        checkModel("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Four fetches, no consume: count 16.
        applyStimulus(1, 32'h03020100, 0, 0, 0, 0);
        applyStimulus(1, 32'h07060504, 0, 0, 0, 0);
        applyStimulus(1, 32'h0B0A0908, 0, 0, 0, 0);
        applyStimulus(1, 32'h0F0E0D0C, 0, 0, 0, 0);
        checkModel("fill16");
        checkOutput("fill16.windowConst", {8'd0, window}, {8'd0, 120'h0E0D0C0B0A09080706050403020100});
        checkOutput("fill16.bytesConst", {123'd0, windowBytes}, 128'd15);

        // Consume 3 with a simultaneous fetch: count 17.
        applyStimulus(1, 32'h13121110, 1, 3, 0, 0);
        checkModel("cons3");
        checkOutput("cons3.byte0", {120'd0, window[7:0]}, 128'h03);
        checkOutput("cons3.eip", {96'd0, headEip}, 128'd3);

        // Fill to 24: 17 -> 20 -> 24, then a held fetch stalls.
        applyStimulus(1, 32'h17161514, 1, 1, 0, 0);
        applyStimulus(1, 32'h1B1A1918, 0, 0, 0, 0);
        checkModel("full24");
        checkOutput("full24.ready", {127'd0, fetchReady}, 128'd0);
        for (int c = 0; c < 3; c++) applyStimulus(1, 32'hDEADBEEF, 0, 0, 0, 0);
        checkModel("stall");
        applyStimulus(1, 32'hDEADBEEF, 1, 4, 0, 0);
        checkModel("drain4");
        checkOutput("drain4.ready", {127'd0, fetchReady}, 128'd1);

        // Drain to 2 bytes, then an over-long consume.
        applyStimulus(0, 0, 1, 15, 0, 0);
        applyStimulus(0, 0, 1, 3, 0, 0);
        checkModel("count2");
        applyStimulus(0, 0, 1, 5, 0, 0);
        checkModel("underrun");
        checkOutput("underrun.err", {127'd0, underrunErr}, 128'd1);

        // Flush wins over fetch and consume; error stays sticky.
        applyStimulus(1, 32'h55555555, 1, 1, 1, 32'hFFFFFFFE);
        checkModel("flush");
        checkOutput("flush.window", {8'd0, window}, 128'd0);
        checkOutput("flush.eip", {96'd0, headEip}, 128'hFFFFFFFE);
        checkOutput("flush.err", {127'd0, underrunErr}, 128'd1);

        // Head address wraps through zero.
        applyStimulus(1, 32'hAABBCCDD, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 0, 0);
        checkModel("wrap");
        checkOutput("wrap.eip", {96'd0, headEip}, 128'h1);

        // Build count 10, then reset asynchronously between edges.
        applyStimulus(1, 32'h0C0B0A09, 0, 0, 0, 0);
        applyStimulus(1, 32'h100F0E0D, 0, 0, 0, 0);
        applyStimulus(1, 32'h14131211, 1, 3, 0, 0);
        checkModel("count10");
        checkOutput("count10.bytes", {123'd0, windowBytes}, 128'd10);
        #3;
        reset = 1'b1;
        #1;
        modelQ.delete();
        modelEip = '0;
        modelErr = 1'b0;
        checkModel("asyncRst");
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        applyStimulus(1, 32'h44332211, 0, 0, 0, 0);
        checkModel("postRst");
        checkOutput("postRst.byte0", {120'd0, window[7:0]}, 128'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
